// File: rtl/quad_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | quad_decoder: quadrature A/B -> filtered enable/up_down steps, err on jump.|
// | Optional QDEC_ERR_CNT_EN adds saturating err_cnt[7:0].   Revision: 1.0     |
// +----------------------------------------------------------------------------+
module quad_decoder #(
  parameter int FILTER_LEN  = 2,
  parameter int DECODE_MODE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_in,
  input  logic       b_in,
  output logic       enable,
  output logic       up_down,
  output logic       err
`ifdef QDEC_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam logic [3:0] CNT_MAX = 4'(FILTER_LEN);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] samp;
  logic [1:0] filt;
  logic [1:0] cand;
  logic [1:0] fill;
  logic [3:0] cnt;
  logic       step_up;
  logic       step_bad;
  logic       step_pass;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_a <= 2'b00;
      sync_b <= 2'b00;
    end else begin
      sync_a <= {sync_a[0], a_in};
      sync_b <= {sync_b[0], b_in};
    end
  end

  assign samp = {sync_a[1], sync_b[1]};

  // Gray-code step classification of {old, new}, AB bit order.
  always_comb begin
    step_up  = 1'b0;
    step_bad = 1'b0;
    case ({filt, samp})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_up  = 1'b1;
      4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_bad = 1'b1;
      default: ;
    endcase
  end

  generate
    if (DECODE_MODE == 4) begin : g_mode4
      assign step_pass = 1'b1;
    end else if (DECODE_MODE == 2) begin : g_mode2
      assign step_pass = filt[1] ^ samp[1];
    end else begin : g_mode1
      assign step_pass = ((filt == 2'b00) && (samp == 2'b10)) ||
                         ((filt == 2'b10) && (samp == 2'b00));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_INIT;
      fill    <= 2'd0;
      cnt     <= 4'd0;
      cand    <= 2'b00;
      filt    <= 2'b00;
      enable  <= 1'b0;
      up_down <= 1'b0;
      err     <= 1'b0;
    end else begin
      enable <= 1'b0;
      err    <= 1'b0;
      case (state)
        // Wait for the cleared synchroniser to refill before adopting its level.
        S_INIT: begin
          if (fill == 2'd2) begin
            filt  <= samp;
            state <= S_RUN;
          end else begin
            fill <= fill + 2'd1;
          end
        end
        S_RUN: begin
          if (samp == filt) begin
            cnt <= 4'd0;
          end else if ((cnt != 4'd0) && (samp != cand)) begin
            cnt  <= 4'd1;
            cand <= samp;
          end else if (cnt == CNT_MAX) begin
            cnt  <= 4'd0;
            filt <= samp;
            if (step_bad) begin
              err <= 1'b1;
            end else if (step_pass) begin
              enable  <= 1'b1;
              up_down <= step_up;
            end
          end else begin
            cnt  <= cnt + 4'd1;
            cand <= samp;
          end
        end
      endcase
    end
  end

`ifdef QDEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt <= 8'd0;
    end else if (err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder.sv
`default_nettype none
// Bench for quad_decoder: three configurations share the encoder inputs and are
// checked every cycle against a sample-history model of the encoder rules.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_in;
  logic       b_in;
  logic [2:0] en;
  logic [2:0] ud;
  logic [2:0] er;
`ifdef QDEC_ERR_CNT_EN
  logic [7:0] ec [3];
`endif

  function automatic int fl_of(input int g);
    return (g == 0) ? 2 : (g == 1) ? 3 : 1;
  endfunction

  function automatic int mode_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 2 : 1;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    quad_decoder #(
      .FILTER_LEN (fl_of(g)),
      .DECODE_MODE(mode_of(g))
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .a_in   (a_in),
      .b_in   (b_in),
      .enable (en[g]),
      .up_down(ud[g]),
      .err    (er[g])
`ifdef QDEC_ERR_CNT_EN
      ,
      .err_cnt(ec[g])
`endif
    );
  end

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  bit         started = 1'b0;
  logic [1:0] d0, d1;
  int         prime [3];
  int         streak [3];
  logic [1:0] fv [3];
  logic [1:0] last [3];
  logic       m_en [3];
  logic       m_ud [3];
  logic       m_err [3];
  int         m_ec [3];
  int         mc_en [3], mc_up [3], mc_err [3], m_last_cyc [3];
  int         dc_en [3], dc_up [3], dc_err [3], last_en_cyc [3];
  int         t_edge;
  logic [1:0] rv;

  // Encoder position around the cycle; up is +1, down is -1, +2 is a skipped step.
  function automatic int pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit mode_pass(input int g, input logic [1:0] o, input logic [1:0] n);
    if (mode_of(g) == 4) return 1'b1;
    if (mode_of(g) == 2) return o[1] != n[1];
    return ((o == 2'b00) && (n == 2'b10)) || ((o == 2'b10) && (n == 2'b00));
  endfunction

  task automatic model_loop();
    logic [1:0] seen;
    int         d;
    forever begin
      @(posedge clk);
      cyc++;
      started = 1'b1;
      if (!rst) begin
        d0 = 2'b00;
        d1 = 2'b00;
        for (int i = 0; i < 3; i++) begin
          prime[i] = 0; streak[i] = 0; fv[i] = 2'b00; last[i] = 2'b00;
          m_en[i] = 1'b0; m_ud[i] = 1'b0; m_err[i] = 1'b0; m_ec[i] = 0;
        end
      end else begin
        seen = d1;
        d1   = d0;
        d0   = {a_in, b_in};
        for (int i = 0; i < 3; i++) begin
          if (m_err[i] && m_ec[i] < 255) m_ec[i]++;
          m_en[i]  = 1'b0;
          m_err[i] = 1'b0;
          if (prime[i] < 2) begin
            prime[i]++;
          end else if (prime[i] == 2) begin
            fv[i]    = seen;
            prime[i] = 3;
          end else begin
            if (streak[i] > 0 && seen == last[i]) streak[i]++;
            else streak[i] = 1;
            last[i] = seen;
            // A new level is taken once seen on FILTER_LEN+1 consecutive clocks.
            if (seen != fv[i] && streak[i] > fl_of(i)) begin
              d = (pos(seen) - pos(fv[i]) + 4) % 4;
              if (d == 2) begin
                m_err[i] = 1'b1;
                mc_err[i]++;
              end else if (mode_pass(i, fv[i], seen)) begin
                m_en[i] = 1'b1;
                m_ud[i] = (d == 1);
                mc_en[i]++;
                if (d == 1) mc_up[i]++;
                m_last_cyc[i] = cyc;
              end
              fv[i] = seen;
            end
          end
        end
      end
    end
  endtask

  task automatic cmpb(input string nm, input int g, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc %0d: dut=%b required=%b", nm, g, cyc, act, exp);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 3; i++) begin
          cmpb("enable", i, en[i], m_en[i]);
          cmpb("up_down", i, ud[i], m_ud[i]);
          cmpb("err", i, er[i], m_err[i]);
`ifdef QDEC_ERR_CNT_EN
          n_cmp++;
          if (int'(ec[i]) != m_ec[i]) begin
            n_fail++;
            $display("FAIL err_cnt[%0d] cyc %0d: dut=%0d required=%0d", i, cyc, ec[i], m_ec[i]);
          end
`endif
          if (en[i] === 1'b1) begin
            dc_en[i]++;
            if (ud[i] === 1'b1) dc_up[i]++;
            last_en_cyc[i] = cyc;
          end
          if (er[i] === 1'b1) dc_err[i]++;
        end
      end
    end
  endtask

  task automatic lit(input string nm, input int act, input int mdl, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: dut=%0d required=%0d", nm, act, exp);
    end
    n_cmp++;
    if (mdl != exp) begin
      n_fail++;
      $display("FAIL %s (model): model=%0d required=%0d", nm, mdl, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      dc_en[i] = 0; dc_up[i] = 0; dc_err[i] = 0; last_en_cyc[i] = 0;
      mc_en[i] = 0; mc_up[i] = 0; mc_err[i] = 0; m_last_cyc[i] = 0;
    end
  endtask

  task automatic drive(input logic [1:0] v, input int n);
    a_in = v[1];
    b_in = v[0];
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b0;
    a_in = 1'b1;
    b_in = 1'b1;
    clr();
    fork
      model_loop();
      cmp_loop();
    join_none
    @(negedge clk);

    // Resting at 11 through reset: priming must not produce a step.
    drive(2'b11, 3);
    rst = 1'b1;
    clr();
    drive(2'b11, 12);
    lit("t1_en0", dc_en[0], mc_en[0], 0);
    lit("t1_err0", dc_err[0], mc_err[0], 0);
    lit("t1_en2", dc_en[2], mc_en[2], 0);

    // One full up cycle.
    rst = 1'b0;
    drive(2'b00, 3);
    rst = 1'b1;
    drive(2'b00, 8);
    clr();
    drive(2'b10, 8); drive(2'b11, 8); drive(2'b01, 8); drive(2'b00, 8);
    lit("t2_en0", dc_en[0], mc_en[0], 4);
    lit("t2_up0", dc_up[0], mc_up[0], 4);
    lit("t2_ud0", int'(ud[0]), int'(m_ud[0]), 1);
    lit("t2_en1", dc_en[1], mc_en[1], 2);
    lit("t2_en2", dc_en[2], mc_en[2], 1);

    // Two full down cycles, with edge-to-pulse latency on the last step.
    clr();
    for (int r = 0; r < 2; r++) begin
      drive(2'b01, 8); drive(2'b11, 8); drive(2'b10, 8);
      t_edge = cyc;
      drive(2'b00, 8);
    end
    lit("t3_en0", dc_en[0], mc_en[0], 8);
    lit("t3_up0", dc_up[0], mc_up[0], 0);
    lit("t3_ud0", int'(ud[0]), int'(m_ud[0]), 0);
    lit("t3_en1", dc_en[1], mc_en[1], 4);
    lit("t3_en2", dc_en[2], mc_en[2], 2);
    lit("t3_lat0", last_en_cyc[0] - t_edge, m_last_cyc[0] - t_edge, 5);

    // Glitches on A: 1 clock is dropped, 3 clocks passes for FILTER_LEN=2.
    clr();
    drive(2'b10, 1); drive(2'b00, 10);
    lit("t4a_en0", dc_en[0], mc_en[0], 0);
    lit("t4a_err0", dc_err[0], mc_err[0], 0);
    lit("t4a_en2", dc_en[2], mc_en[2], 0);
    clr();
    drive(2'b10, 3); drive(2'b00, 10);
    lit("t4b_en0", dc_en[0], mc_en[0], 2);
    lit("t4b_up0", dc_up[0], mc_up[0], 1);
    lit("t4b_ud0", int'(ud[0]), int'(m_ud[0]), 0);
    lit("t4b_en1", dc_en[1], mc_en[1], 0);
    lit("t4b_en2", dc_en[2], mc_en[2], 2);

    // Illegal double-bit jumps.
    clr();
    drive(2'b11, 8);
    lit("t5_err0", dc_err[0], mc_err[0], 1);
    lit("t5_en0", dc_en[0], mc_en[0], 0);
    lit("t5_ud0", int'(ud[0]), int'(m_ud[0]), 0);
`ifdef QDEC_ERR_CNT_EN
    lit("t5_ecnt0", int'(ec[0]), m_ec[0], 1);
`endif
    for (int j = 0; j < 300; j++) drive((j % 2 == 0) ? 2'b00 : 2'b11, 5);
    drive(2'b11, 8);
    lit("t5_err0_300", dc_err[0], mc_err[0], 301);
    lit("t5_en0_300", dc_en[0], mc_en[0], 0);
`ifdef QDEC_ERR_CNT_EN
    lit("t5_ecnt0_sat", int'(ec[0]), m_ec[0], 255);
    lit("t5_ecnt1_sat", int'(ec[1]), m_ec[1], 255);
`endif

    // Reset in the middle of a step: it is discarded and re-primed silently.
    rst = 1'b0;
    drive(2'b00, 3);
    rst = 1'b1;
    drive(2'b00, 8);
    clr();
    drive(2'b10, 2);
    rst = 1'b0;
    drive(2'b10, 3);
    rst = 1'b1;
    drive(2'b10, 10);
    lit("t6_en0", dc_en[0], mc_en[0], 0);
    lit("t6_err0", dc_err[0], mc_err[0], 0);
    lit("t6_en2", dc_en[2], mc_en[2], 0);
    drive(2'b00, 8);
    lit("t6_en2_dn", dc_en[2], mc_en[2], 1);
    lit("t6_up2_dn", dc_up[2], mc_up[2], 0);

    // Random encoder activity with occasional resets.
    for (int k = 0; k < 600; k++) begin
      rv = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        drive(rv, $urandom_range(1, 3));
        rst = 1'b1;
      end else begin
        drive(rv, $urandom_range(1, 7));
      end
    end
    drive(2'b00, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
